// File: rtl/audioport_play_controller.sv
// Audioport play controller: APB write decode, FIFO push/pop strobes and playback/IRQ sequencing.
// Defining AUDIOPORT_STATUS_REG_EN adds a readable status register at STATUS_REG_ADDRESS.
module audioport_play_controller #(
    parameter int unsigned AUDIO_FIFO_SIZE    = 8,
    parameter logic [31:0] LEFT_FIFO_ADDRESS  = 32'h0000_1000,
    parameter logic [31:0] RIGHT_FIFO_ADDRESS = 32'h0000_1004,
    parameter logic [31:0] CMD_REG_ADDRESS    = 32'h0000_1008,
    parameter logic [31:0] STATUS_REG_ADDRESS = 32'h0000_100C,
    parameter logic [31:0] CMD_START          = 32'h0000_0001,
    parameter logic [31:0] CMD_STOP           = 32'h0000_0002,
    parameter logic [31:0] CMD_IRQACK         = 32'h0000_AAAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR,
    input  logic        tick_in,
    output logic        left_wr_out,
    output logic        right_wr_out,
    output logic [23:0] sample_out,
    output logic        fifo_pop_out,
    output logic        play_out,
    output logic        irq_out
);

    localparam int unsigned     CntW    = $clog2(AUDIO_FIFO_SIZE + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(AUDIO_FIFO_SIZE);

    localparam logic [1:0] StStopped = 2'd0;
    localparam logic [1:0] StPlaying = 2'd1;
    localparam logic [1:0] StIrq     = 2'd2;

    logic            wr_xfer;
    logic            left_wr;
    logic            right_wr;
    logic            cmd_start;
    logic            cmd_stop;
    logic            cmd_irqack;
    logic            cnt_clear;

    logic [1:0]      state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            left_wr_d, left_wr_q;
    logic            right_wr_d, right_wr_q;
    logic [23:0]     sample_d, sample_q;
    logic            pop_d, pop_q;

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    always_comb begin
        wr_xfer    = PSEL && PENABLE && PWRITE && PREADY;
        left_wr    = wr_xfer && (PADDR == LEFT_FIFO_ADDRESS);
        right_wr   = wr_xfer && (PADDR == RIGHT_FIFO_ADDRESS);
        cmd_start  = wr_xfer && (PADDR == CMD_REG_ADDRESS) && (PWDATA == CMD_START);
        cmd_stop   = wr_xfer && (PADDR == CMD_REG_ADDRESS) && (PWDATA == CMD_STOP);
        cmd_irqack = wr_xfer && (PADDR == CMD_REG_ADDRESS) && (PWDATA == CMD_IRQACK);
        // A refill or an acknowledge restarts the consumption count.
        cnt_clear  = left_wr || right_wr || cmd_irqack;
    end

    always_comb begin
        left_wr_d  = left_wr;
        right_wr_d = right_wr;
        sample_d   = (left_wr || right_wr) ? PWDATA[23:0] : sample_q;
        pop_d      = tick_in && (state_q != StStopped);
    end

    // Clear beats tick: a tick coinciding with a clear still pops but is not counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StStopped: begin
                cnt_d = '0;
                if (cmd_start) begin
                    state_d = StPlaying;
                end
            end
            StPlaying: begin
                if (cmd_stop) begin
                    state_d = StStopped;
                    cnt_d   = '0;
                end else if (cnt_clear) begin
                    cnt_d = '0;
                end else begin
                    if (cnt_q == CntFull) begin
                        state_d = StIrq;
                    end
                    if (tick_in && (cnt_q != CntFull)) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StIrq: begin
                if (cmd_stop) begin
                    state_d = StStopped;
                    cnt_d   = '0;
                end else if (cnt_clear) begin
                    state_d = StPlaying;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StStopped;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StStopped;
            cnt_q      <= '0;
            left_wr_q  <= 1'b0;
            right_wr_q <= 1'b0;
            sample_q   <= '0;
            pop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            left_wr_q  <= left_wr_d;
            right_wr_q <= right_wr_d;
            sample_q   <= sample_d;
            pop_q      <= pop_d;
        end
    end

    assign left_wr_out  = left_wr_q;
    assign right_wr_out = right_wr_q;
    assign sample_out   = sample_q;
    assign fifo_pop_out = pop_q;
    assign play_out     = (state_q != StStopped);
    assign irq_out      = (state_q == StIrq);

    logic unused_pwdata_hi;
    assign unused_pwdata_hi = ^PWDATA[31:24];

`ifdef AUDIOPORT_STATUS_REG_EN
    logic [7:0] cnt_byte;

    always_comb begin
        cnt_byte = 8'(cnt_q);
        PRDATA   = '0;
        if (PSEL && PENABLE && !PWRITE && (PADDR == STATUS_REG_ADDRESS)) begin
            PRDATA = {16'h0000, cnt_byte, 6'b000000, irq_out, play_out};
        end
    end
`else
    assign PRDATA = '0;

    logic unused_status_addr;
    assign unused_status_addr = ^STATUS_REG_ADDRESS;
`endif

endmodule

// File: tb/tb_audioport_play_controller.sv
// Bench for audioport_play_controller: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural playback model.
module tb_audioport_play_controller;

    localparam int unsigned Size     = 8;
    localparam logic [31:0] AddrL    = 32'h0000_1000;
    localparam logic [31:0] AddrR    = 32'h0000_1004;
    localparam logic [31:0] AddrCmd  = 32'h0000_1008;
    localparam logic [31:0] AddrStat = 32'h0000_100C;
    localparam logic [31:0] Start    = 32'h0000_0001;
    localparam logic [31:0] Stop     = 32'h0000_0002;
    localparam logic [31:0] Ack      = 32'h0000_AAAA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic        tick_in = 1'b0;
    logic        left_wr_out;
    logic        right_wr_out;
    logic [23:0] sample_out;
    logic        fifo_pop_out;
    logic        play_out;
    logic        irq_out;

    audioport_play_controller #(
        .AUDIO_FIFO_SIZE(Size)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PREADY      (PREADY),
        .PRDATA      (PRDATA),
        .PSLVERR     (PSLVERR),
        .tick_in     (tick_in),
        .left_wr_out (left_wr_out),
        .right_wr_out(right_wr_out),
        .sample_out  (sample_out),
        .fifo_pop_out(fifo_pop_out),
        .play_out    (play_out),
        .irq_out     (irq_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: playing flag, interrupt flag and consumed-sample count.
    bit          m_valid = 1'b0;
    bit          m_active = 1'b0;
    bit          m_irq = 1'b0;
    int          m_cnt = 0;
    bit          e_left = 1'b0;
    bit          e_right = 1'b0;
    bit          e_pop = 1'b0;
    logic [23:0] e_sample = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic wt, lw, rw, cmd, start, stop, ack;
        wt    = PSEL && PENABLE && PWRITE;
        lw    = wt && (PADDR == AddrL);
        rw    = wt && (PADDR == AddrR);
        cmd   = wt && (PADDR == AddrCmd);
        start = cmd && (PWDATA == Start);
        stop  = cmd && (PWDATA == Stop);
        ack   = cmd && (PWDATA == Ack);
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_irq    = 1'b0;
            m_cnt    = 0;
            e_left   = 1'b0;
            e_right  = 1'b0;
            e_pop    = 1'b0;
            e_sample = '0;
            return;
        end
        e_pop   = tick_in && m_active;
        e_left  = lw;
        e_right = rw;
        if (lw || rw) e_sample = PWDATA[23:0];
        if (!m_active) begin
            m_active = start;
        end else if (stop) begin
            m_active = 1'b0;
            m_irq    = 1'b0;
            m_cnt    = 0;
        end else if (lw || rw || ack) begin
            m_irq = 1'b0;
            m_cnt = 0;
        end else begin
            // The interrupt is raised one edge after the count reaches a full FIFO.
            if (m_cnt == Size) m_irq = 1'b1;
            if (tick_in && m_cnt < Size) m_cnt++;
        end
    endtask

    function automatic logic [31:0] exp_prdata();
`ifdef AUDIOPORT_STATUS_REG_EN
        if (PSEL && PENABLE && !PWRITE && PADDR == AddrStat)
            return {16'h0000, 8'(m_cnt), 6'b000000, m_irq, m_active};
`endif
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("play_out", play_out, m_active);
            check("irq_out", irq_out, m_irq);
            check("fifo_pop_out", fifo_pop_out, e_pop);
            check("left_wr_out", left_wr_out, e_left);
            check("right_wr_out", right_wr_out, e_right);
            if (e_left || e_right) check("sample_out", sample_out, e_sample);
            check("PRDATA", PRDATA, exp_prdata());
            check("PREADY", PREADY, 1);
            check("PSLVERR", PSLVERR, 0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        tick_in = 1'b0;
    endtask

    // Returns just after the edge that samples the write transfer.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWDATA  = data;
        cycle();
        PENABLE = 1'b1;
        cycle();
        set_idle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cycle();
            tick_in = 1'b0;
            cycle();
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        cycle();
        cycle();
        check("rst play_out", play_out, 0);
        check("rst irq_out", irq_out, 0);
        check("rst left_wr_out", left_wr_out, 0);
        check("rst right_wr_out", right_wr_out, 0);
        check("rst fifo_pop_out", fifo_pop_out, 0);
        check("rst sample_out", sample_out, 0);
        check("rst PRDATA", PRDATA, 0);
        check("rst PREADY", PREADY, 1);
        check("rst PSLVERR", PSLVERR, 0);
        rst = 1'b0;
        cycle();

        // Eight spaced ticks raise the interrupt two clocks after the last one.
        apb_write(AddrCmd, Start);
        check("start play_out", play_out, 1);
        for (int i = 0; i < 8; i++) begin
            tick_in = 1'b1;
            cycle();
            tick_in = 1'b0;
            check("tick pop", fifo_pop_out, 1);
            check("tick irq +1", irq_out, 0);
            cycle();
            check("tick pop gap", fifo_pop_out, 0);
            check("tick irq +2", irq_out, (i == 7) ? 1 : 0);
        end
        check("irq play_out", play_out, 1);

        // Acknowledge drops the interrupt; eight more ticks re-raise it.
        apb_write(AddrCmd, Ack);
        check("ack irq_out", irq_out, 0);
        ticks(7);
        cycle();
        cycle();
        check("ack 7 ticks irq", irq_out, 0);
        ticks(1);
        check("ack 8 ticks irq", irq_out, 1);

        // FIFO writes in IRQ clear it and push the sample.
        apb_write(AddrL, 32'h00AB_CDEF);
        check("irq left wr", left_wr_out, 1);
        check("irq left sample", sample_out, 24'hABCDEF);
        check("irq left clears", irq_out, 0);
        cycle();
        check("left wr one cycle", left_wr_out, 0);
        apb_write(AddrR, 32'hFF12_3456);
        check("right wr", right_wr_out, 1);
        check("right sample", sample_out, 24'h123456);
        check("right not left", left_wr_out, 0);

        // A refill after seven ticks keeps the interrupt away for seven more.
        ticks(7);
        apb_write(AddrL, 32'h00AB_CDEF);
        check("refill left wr", left_wr_out, 1);
        check("refill sample", sample_out, 24'hABCDEF);
        ticks(7);
        cycle();
        cycle();
        cycle();
        check("refill irq stays 0", irq_out, 0);
        ticks(1);
        check("refill 8th tick irq", irq_out, 1);

        // STOP at count 5, ticks ignored, then a fresh eight are needed.
        apb_write(AddrCmd, Ack);
        ticks(5);
        apb_write(AddrCmd, Stop);
        check("stop play_out", play_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick_in = 1'b1;
            cycle();
            tick_in = 1'b0;
            check("stopped pop", fifo_pop_out, 0);
            cycle();
        end
        apb_write(AddrCmd, Start);
        check("restart play_out", play_out, 1);
        ticks(7);
        cycle();
        cycle();
        check("restart 7 ticks irq", irq_out, 0);
        ticks(1);
        check("restart 8 ticks irq", irq_out, 1);

        // Status read after three ticks.
        apb_write(AddrCmd, Stop);
        apb_write(AddrCmd, Start);
        ticks(3);
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b0;
        PADDR   = AddrStat;
        #1;
`ifdef AUDIOPORT_STATUS_REG_EN
        check("status read", PRDATA, 32'h0000_0301);
`else
        check("status read", PRDATA, 32'h0000_0000);
`endif
        cycle();
        PADDR = AddrL;
        #1;
        check("other read", PRDATA, 32'h0000_0000);
        set_idle();

        // Incomplete transfers push nothing.
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PADDR  = AddrL;
        cycle();
        check("no penable wr", left_wr_out, 0);
        PENABLE = 1'b1;
        PWRITE  = 1'b0;
        cycle();
        check("read no wr", left_wr_out, 0);
        set_idle();

        // Reset mid-playback.
        ticks(2);
        rst     = 1'b1;
        tick_in = 1'b1;
        cycle();
        check("midrst play_out", play_out, 0);
        check("midrst pop", fifo_pop_out, 0);
        rst     = 1'b0;
        tick_in = 1'b0;
        cycle();

        for (int n = 0; n < 5000; n++) begin
            PSEL    = ($urandom_range(0, 5) == 0);
            PENABLE = ($urandom_range(0, 1) == 1);
            PWRITE  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       PADDR = AddrL;
                1:       PADDR = AddrR;
                2, 3:    PADDR = AddrCmd;
                4:       PADDR = AddrStat;
                default: PADDR = $urandom();
            endcase
            case ($urandom_range(0, 3))
                0:       PWDATA = Start;
                1:       PWDATA = Stop;
                2:       PWDATA = Ack;
                default: PWDATA = $urandom();
            endcase
            tick_in = ($urandom_range(0, 9) < 4);
            rst     = ($urandom_range(0, 999) == 0);
            cycle();
        end
        set_idle();
        rst = 1'b0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
